// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: fetch PC, IF/ID and ID/EX latches under hazard-unit control,
// plus saturating stall / flush / issue performance counters.
module pipe_front_regs #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     CTRL_W   = 16,
    parameter int unsigned     CNT_W    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush_IFID,
    input  logic              flush_IDEX,
    input  logic              BranchTaken,
    input  logic [XLEN-1:0]   branch_target,
    input  logic [31:0]       instr_IF,
    input  logic [CTRL_W-1:0] ctrl_ID,
    input  logic [4:0]        rs1_ID,
    input  logic [4:0]        rs2_ID,
    input  logic [4:0]        rd_ID,
    input  logic [XLEN-1:0]   rdata1_ID,
    input  logic [XLEN-1:0]   rdata2_ID,
    output logic [XLEN-1:0]   pc_IF,
    output logic [XLEN-1:0]   pc_ID,
    output logic [31:0]       instr_ID,
    output logic              valid_ID,
    output logic [XLEN-1:0]   pc_EX,
    output logic [CTRL_W-1:0] ctrl_EX,
    output logic [4:0]        rs1_EX,
    output logic [4:0]        rs2_EX,
    output logic [4:0]        rd_EX,
    output logic [XLEN-1:0]   rdata1_EX,
    output logic [XLEN-1:0]   rdata2_EX,
    output logic              valid_EX,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  issue_cnt
);

    localparam logic [31:0]       Nop    = 32'h0000_0013;
    localparam logic [XLEN-1:0]   PcStep = XLEN'(4);
    localparam logic [CNT_W-1:0]  CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CntMax = '1;

    logic [XLEN-1:0]   pc_if_q, pc_if_d;
    logic [XLEN-1:0]   pc_id_q, pc_id_d;
    logic [31:0]       instr_id_q, instr_id_d;
    logic              valid_id_q, valid_id_d;
    logic [XLEN-1:0]   pc_ex_q, pc_ex_d;
    logic [CTRL_W-1:0] ctrl_ex_q, ctrl_ex_d;
    logic [4:0]        rs1_ex_q, rs1_ex_d;
    logic [4:0]        rs2_ex_q, rs2_ex_d;
    logic [4:0]        rd_ex_q, rd_ex_d;
    logic [XLEN-1:0]   rdata1_ex_q, rdata1_ex_d;
    logic [XLEN-1:0]   rdata2_ex_q, rdata2_ex_d;
    logic              valid_ex_q, valid_ex_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;

    logic redirect;
    logic flush_evt;
    logic issue_evt;

    // A branch seen during a stall was resolved on stale operands, so it is dropped.
    assign redirect  = BranchTaken & ~stall;
    assign flush_evt = (flush_IFID & ~stall) | flush_IDEX;
    assign issue_evt = valid_id_q & ~flush_IDEX;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        return (en && (cnt != CntMax)) ? cnt + CntOne : cnt;
    endfunction

    // Fetch PC
    always_comb begin
        pc_if_d = pc_if_q;
        if (redirect) begin
            pc_if_d = branch_target;
        end else if (!stall) begin
            pc_if_d = pc_if_q + PcStep;
        end
    end

    // IF/ID latch
    always_comb begin
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        valid_id_d = valid_id_q;
        if (stall) begin
            pc_id_d    = pc_id_q;
        end else if (flush_IFID) begin
            instr_id_d = Nop;
            valid_id_d = 1'b0;
        end else begin
            pc_id_d    = pc_if_q;
            instr_id_d = instr_IF;
            valid_id_d = 1'b1;
        end
    end

    // ID/EX latch; a stall does not hold EX so the older instruction can drain and forward.
    always_comb begin
        pc_ex_d     = pc_ex_q;
        ctrl_ex_d   = ctrl_ex_q;
        rs1_ex_d    = rs1_ex_q;
        rs2_ex_d    = rs2_ex_q;
        rd_ex_d     = rd_ex_q;
        rdata1_ex_d = rdata1_ex_q;
        rdata2_ex_d = rdata2_ex_q;
        valid_ex_d  = valid_ex_q;
        if (flush_IDEX) begin
            ctrl_ex_d   = '0;
            rs1_ex_d    = '0;
            rs2_ex_d    = '0;
            rd_ex_d     = '0;
            rdata1_ex_d = '0;
            rdata2_ex_d = '0;
            valid_ex_d  = 1'b0;
        end else begin
            pc_ex_d     = pc_id_q;
            ctrl_ex_d   = valid_id_q ? ctrl_ID : '0;
            rs1_ex_d    = rs1_ID;
            rs2_ex_d    = rs2_ID;
            rd_ex_d     = rd_ID;
            rdata1_ex_d = rdata1_ID;
            rdata2_ex_d = rdata2_ID;
            valid_ex_d  = valid_id_q;
        end
    end

    // Performance counters
    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, stall);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_evt);
        issue_cnt_d = sat_inc(issue_cnt_q, issue_evt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_if_q     <= RESET_PC;
            pc_id_q     <= '0;
            instr_id_q  <= Nop;
            valid_id_q  <= 1'b0;
            pc_ex_q     <= '0;
            ctrl_ex_q   <= '0;
            rs1_ex_q    <= '0;
            rs2_ex_q    <= '0;
            rd_ex_q     <= '0;
            rdata1_ex_q <= '0;
            rdata2_ex_q <= '0;
            valid_ex_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            pc_if_q     <= pc_if_d;
            pc_id_q     <= pc_id_d;
            instr_id_q  <= instr_id_d;
            valid_id_q  <= valid_id_d;
            pc_ex_q     <= pc_ex_d;
            ctrl_ex_q   <= ctrl_ex_d;
            rs1_ex_q    <= rs1_ex_d;
            rs2_ex_q    <= rs2_ex_d;
            rd_ex_q     <= rd_ex_d;
            rdata1_ex_q <= rdata1_ex_d;
            rdata2_ex_q <= rdata2_ex_d;
            valid_ex_q  <= valid_ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign pc_IF     = pc_if_q;
    assign pc_ID     = pc_id_q;
    assign instr_ID  = instr_id_q;
    assign valid_ID  = valid_id_q;
    assign pc_EX     = pc_ex_q;
    assign ctrl_EX   = ctrl_ex_q;
    assign rs1_EX    = rs1_ex_q;
    assign rs2_EX    = rs2_ex_q;
    assign rd_EX     = rd_ex_q;
    assign rdata1_EX = rdata1_ex_q;
    assign rdata2_EX = rdata2_ex_q;
    assign valid_EX  = valid_ex_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: table of per-cycle hazard commands with hand-derived expected state,
// plus a narrow-counter / wrap-PC instance for saturation and PC overflow.
module tb_pipe_front_regs;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        rst, stall, flush_IFID, flush_IDEX, BranchTaken;
    logic [31:0] branch_target, instr_IF, rdata1_ID, rdata2_ID;
    logic [15:0] ctrl_ID;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID;
    logic [31:0] pc_IF, pc_ID, instr_ID, pc_EX, rdata1_EX, rdata2_EX;
    logic        valid_ID, valid_EX;
    logic [15:0] ctrl_EX;
    logic [4:0]  rs1_EX, rs2_EX, rd_EX;
    logic [31:0] stall_cnt, flush_cnt, issue_cnt;

    pipe_front_regs dut (
        .clk(clk), .rst(rst), .stall(stall), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .BranchTaken(BranchTaken), .branch_target(branch_target), .instr_IF(instr_IF),
        .ctrl_ID(ctrl_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .rdata1_ID(rdata1_ID), .rdata2_ID(rdata2_ID), .pc_IF(pc_IF), .pc_ID(pc_ID),
        .instr_ID(instr_ID), .valid_ID(valid_ID), .pc_EX(pc_EX), .ctrl_EX(ctrl_EX),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .rdata1_EX(rdata1_EX),
        .rdata2_EX(rdata2_EX), .valid_EX(valid_EX), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .issue_cnt(issue_cnt)
    );

    // Narrow-counter instance starting near the top of the address space
    logic        rst2, stall2;
    logic        z1 = 1'b0;
    logic [31:0] z32 = '0;
    logic [15:0] z16 = '0;
    logic [4:0]  z5 = '0;
    logic [31:0] pc_IF2, pc_ID2, instr_ID2, pc_EX2, rdata1_EX2, rdata2_EX2;
    logic        valid_ID2, valid_EX2;
    logic [15:0] ctrl_EX2;
    logic [4:0]  rs1_EX2, rs2_EX2, rd_EX2;
    logic [3:0]  stall_cnt2, flush_cnt2, issue_cnt2;

    pipe_front_regs #(.CNT_W(4), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2), .stall(stall2), .flush_IFID(z1), .flush_IDEX(z1),
        .BranchTaken(z1), .branch_target(z32), .instr_IF(z32),
        .ctrl_ID(z16), .rs1_ID(z5), .rs2_ID(z5), .rd_ID(z5),
        .rdata1_ID(z32), .rdata2_ID(z32), .pc_IF(pc_IF2), .pc_ID(pc_ID2),
        .instr_ID(instr_ID2), .valid_ID(valid_ID2), .pc_EX(pc_EX2), .ctrl_EX(ctrl_EX2),
        .rs1_EX(rs1_EX2), .rs2_EX(rs2_EX2), .rd_EX(rd_EX2), .rdata1_EX(rdata1_EX2),
        .rdata2_EX(rdata2_EX2), .valid_EX(valid_EX2), .stall_cnt(stall_cnt2),
        .flush_cnt(flush_cnt2), .issue_cnt(issue_cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle ID-stage payload is a fixed function of the vector index.
    function automatic logic [31:0] instr_of(int i); return 32'h1000_0000 + i; endfunction
    function automatic logic [15:0] ctrl_of(int i);  return 16'hA000 + 16'(i); endfunction
    function automatic logic [4:0]  rs1_of(int i);   return 5'(i); endfunction
    function automatic logic [4:0]  rs2_of(int i);   return 5'(i + 1); endfunction
    function automatic logic [4:0]  rd_of(int i);    return 5'(i + 2); endfunction
    function automatic logic [31:0] rd1_of(int i);   return 32'hD100_0000 + i; endfunction
    function automatic logic [31:0] rd2_of(int i);   return 32'hD200_0000 + i; endfunction

    // exidx: index whose ID payload sits in ID/EX; -1 flushed bubble (pc_EX unchecked), -2 reset
    typedef struct {
        logic        rst, stall, fifid, fidex, br;
        logic [31:0] tgt;
        logic [31:0] pc_if, pc_id, instr_id;
        logic        vid;
        logic [31:0] pc_ex;
        int          exidx;
        logic        vex;
        logic [31:0] sc, fc, ic;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic fi, logic fe, logic b, logic [31:0] t,
                                logic [31:0] pif, logic [31:0] pid, logic [31:0] iid,
                                logic vid, logic [31:0] pex, int exidx, logic vex,
                                logic [31:0] sc, logic [31:0] fc, logic [31:0] ic);
        vec_t v;
        v.rst = r; v.stall = s; v.fifid = fi; v.fidex = fe; v.br = b; v.tgt = t;
        v.pc_if = pif; v.pc_id = pid; v.instr_id = iid; v.vid = vid;
        v.pc_ex = pex; v.exidx = exidx; v.vex = vex; v.sc = sc; v.fc = fc; v.ic = ic;
        return v;
    endfunction

    vec_t vecs[14];
    vec_t sb[$];

    initial begin
        //            rst s fi fe br tgt           pcIF        pcID        instrID      vID pcEX
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   Nop,         0, 32'h0,   -2, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h4,   32'h0,   instr_of(1), 1, 32'h0,    1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h8,   32'h4,   instr_of(2), 1, 32'h0,    2, 1, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,   32'hC,   32'h8,   instr_of(3), 1, 32'h4,    3, 1, 0, 0, 2);
        // load-use bubble: stall + flush_IDEX
        vecs[4]  = mk(0, 1, 0, 1, 0, 32'h0,   32'hC,   32'h8,   instr_of(3), 1, 32'h0,   -1, 0, 1, 1, 2);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h10,  32'hC,   instr_of(5), 1, 32'h8,    5, 1, 1, 1, 3);
        // taken branch with IF/ID flush
        vecs[6]  = mk(0, 0, 1, 0, 1, 32'h100, 32'h100, 32'hC,   Nop,         0, 32'hC,    6, 1, 1, 2, 4);
        vecs[7]  = mk(0, 0, 0, 0, 0, 32'h0,   32'h104, 32'h100, instr_of(7), 1, 32'hC,    7, 0, 1, 2, 4);
        // branch during stall is ignored, then honoured
        vecs[8]  = mk(0, 1, 0, 0, 1, 32'h200, 32'h104, 32'h100, instr_of(7), 1, 32'h100,  8, 1, 2, 2, 5);
        vecs[9]  = mk(0, 0, 0, 0, 1, 32'h200, 32'h200, 32'h104, instr_of(9), 1, 32'h100,  9, 1, 2, 2, 6);
        // flush_IFID during stall is ignored and not counted
        vecs[10] = mk(0, 1, 1, 0, 0, 32'h0,   32'h200, 32'h104, instr_of(9), 1, 32'h104, 10, 1, 3, 2, 7);
        // both flushes in one cycle count once
        vecs[11] = mk(0, 0, 1, 1, 0, 32'h0,   32'h204, 32'h104, Nop,         0, 32'h0,   -1, 0, 3, 3, 7);
        // reset overrides everything
        vecs[12] = mk(1, 1, 0, 1, 1, 32'h300, 32'h0,   32'h0,   Nop,         0, 32'h0,   -2, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 32'h0,   32'h4,   32'h0,   instr_of(13),1, 32'h0,   13, 0, 0, 0, 0);

        rst2 = 1'b1;
        stall2 = 1'b0;

        for (int i = 0; i < 14; i++) begin
            vec_t e;
            string tag;
            rst = vecs[i].rst; stall = vecs[i].stall; flush_IFID = vecs[i].fifid;
            flush_IDEX = vecs[i].fidex; BranchTaken = vecs[i].br; branch_target = vecs[i].tgt;
            instr_IF = instr_of(i); ctrl_ID = ctrl_of(i); rs1_ID = rs1_of(i); rs2_ID = rs2_of(i);
            rd_ID = rd_of(i); rdata1_ID = rd1_of(i); rdata2_ID = rd2_of(i);
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            tag = $sformatf("v%0d", i);
            check({tag, " pc_IF"},     pc_IF,     e.pc_if);
            check({tag, " pc_ID"},     pc_ID,     e.pc_id);
            check({tag, " instr_ID"},  instr_ID,  e.instr_id);
            check({tag, " valid_ID"},  valid_ID,  e.vid);
            check({tag, " valid_EX"},  valid_EX,  e.vex);
            if (e.exidx != -1) check({tag, " pc_EX"}, pc_EX, e.pc_ex);
            if (e.exidx >= 0) begin
                check({tag, " ctrl_EX"},   ctrl_EX,   e.vex ? ctrl_of(e.exidx) : 16'h0);
                check({tag, " rs1_EX"},    rs1_EX,    rs1_of(e.exidx));
                check({tag, " rs2_EX"},    rs2_EX,    rs2_of(e.exidx));
                check({tag, " rd_EX"},     rd_EX,     rd_of(e.exidx));
                check({tag, " rdata1_EX"}, rdata1_EX, rd1_of(e.exidx));
                check({tag, " rdata2_EX"}, rdata2_EX, rd2_of(e.exidx));
            end else begin
                check({tag, " ctrl_EX"},   ctrl_EX,   16'h0);
                check({tag, " rs1_EX"},    rs1_EX,    5'h0);
                check({tag, " rs2_EX"},    rs2_EX,    5'h0);
                check({tag, " rd_EX"},     rd_EX,     5'h0);
                check({tag, " rdata1_EX"}, rdata1_EX, 32'h0);
                check({tag, " rdata2_EX"}, rdata2_EX, 32'h0);
            end
            check({tag, " stall_cnt"}, stall_cnt, e.sc);
            check({tag, " flush_cnt"}, flush_cnt, e.fc);
            check({tag, " issue_cnt"}, issue_cnt, e.ic);
        end

        // Narrow instance: PC wrap, then stall counter saturation at 15
        check("w reset pc_IF", pc_IF2, 32'hFFFF_FFFC);
        check("w reset stall_cnt", stall_cnt2, 4'h0);
        rst2 = 1'b0;
        @(posedge clk); #1;
        check("w wrap pc_IF", pc_IF2, 32'h0);
        check("w wrap valid_ID", valid_ID2, 1'b1);
        check("w wrap pc_ID", pc_ID2, 32'hFFFF_FFFC);
        stall2 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 14) check("w stall_cnt 14", stall_cnt2, 4'hE);
            if (c == 15) check("w stall_cnt 15", stall_cnt2, 4'hF);
        end
        check("w stall_cnt sat", stall_cnt2, 4'hF);
        check("w stall pc hold", pc_IF2, 32'h0);
        check("w issue_cnt", issue_cnt2, 4'hF);
        check("w flush_cnt", flush_cnt2, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
